// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: shared definitions for the frame-buffer BRAM arbiter.
// Holds the arbiter state encoding, default bus widths and the
// write-FIFO high-water offset that lets writes pre-empt read bursts.
package fb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } arbState_e;

   localparam int DEF_ADDR_W        = 14;
   localparam int DEF_DATA_W        = 8;
   localparam int HIGH_WATER_OFFSET = 2;

endpackage

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: synchronous first-word-fall-through FIFO that buffers
// capture-side pixel writes until the arbiter grants them a BRAM slot.
// DEPTH must be a power of two so the pointers wrap for free.
module fb_wr_fifo
   import fb_arb_pkg::*;
#(
   parameter int WIDTH = DEF_ADDR_W + DEF_DATA_W,
   parameter int DEPTH = 8
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  logic                    push_i,
   input  logic [WIDTH-1:0]        pushData_i,
   input  logic                    pop_i,
   output logic [WIDTH-1:0]        popData_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  level_o
);

   localparam int PtrW = $clog2(DEPTH);
   localparam logic [PtrW:0] FullLevel = (PtrW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wrPtr_q;
   logic [PtrW-1:0]  rdPtr_q;
   logic [PtrW:0]    level_q;
   logic             doPush;
   logic             doPop;

   // A push into a full FIFO is only taken when the head leaves the same cycle.
   assign doPop     = pop_i && (level_q != '0);
   assign doPush    = push_i && ((level_q != FullLevel) || doPop);
   assign full_o    = (level_q == FullLevel);
   assign empty_o   = (level_q == '0);
   assign level_o   = level_q;
   assign popData_o = mem_q[rdPtr_q];

   // Storage array; contents need no reset since the pointers define validity.
   always_ff @(posedge clock_i) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= pushData_i;
      end
   end

   // Pointer and occupancy bookkeeping, cleared by reset to empty the FIFO.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         case ({doPush, doPop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one single-port BRAM between a capture write stream
// (buffered in fb_wr_fifo) and display prefetch read bursts. Each cycle it
// issues one write, one read beat, or nothing; writes win when no burst is
// running or when the FIFO nears full. Optional macro FB_ARBITER_STATS_EN
// enables the saturating dropped-write counter behind DROP_COUNT.
module fb_arbiter
   import fb_arb_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              O_CLK,
   input  logic              RESET,
   input  logic              WR_VALID,
   input  logic [ADDR_W-1:0] WR_ADDR,
   input  logic [DATA_W-1:0] WR_DATA,
   input  logic              RD_REQ,
   input  logic [ADDR_W-1:0] RD_ADDR,
   input  logic [7:0]        RD_LEN,
   output logic              RD_BUSY,
   output logic              RD_DVALID,
   output logic [DATA_W-1:0] RD_DATA,
   output logic [ADDR_W-1:0] BRAM_ADDR,
   output logic [DATA_W-1:0] BRAM_DIN,
   output logic              BRAM_WE,
   input  logic [DATA_W-1:0] BRAM_DOUT,
   output logic              OVERFLOW,
   output logic [15:0]       DROP_COUNT
);

   localparam int EntryW = ADDR_W + DATA_W;
   localparam int LevelW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [LevelW-1:0] HighWater = LevelW'(FIFO_DEPTH - HIGH_WATER_OFFSET);

   logic [EntryW-1:0] fifoEntry;
   logic              fifoFull;
   logic              fifoEmpty;
   logic [LevelW-1:0] fifoLevel;
   logic              wrIssue;
   logic              rdIssue;
   logic              pushDropped;

   arbState_e         state_q,     state_d;
   logic [ADDR_W-1:0] bramAddr_q,  bramAddr_d;
   logic [DATA_W-1:0] bramDin_q,   bramDin_d;
   logic              bramWe_q,    bramWe_d;
   logic              busy_q,      busy_d;
   logic [ADDR_W-1:0] burstAddr_q, burstAddr_d;
   logic [8:0]        beatsLeft_q, beatsLeft_d;
   logic              dvalid_q,    dvalid_d;
   logic              overflow_q,  overflow_d;

   fb_wr_fifo #(
      .WIDTH (EntryW),
      .DEPTH (FIFO_DEPTH)
   ) uFifo (
      .clock_i    (O_CLK),
      .reset_i    (RESET),
      .push_i     (WR_VALID),
      .pushData_i ({WR_ADDR, WR_DATA}),
      .pop_i      (wrIssue),
      .popData_o  (fifoEntry),
      .full_o     (fifoFull),
      .empty_o    (fifoEmpty),
      .level_o    (fifoLevel)
   );

   assign wrIssue     = !fifoEmpty && (!busy_q || (fifoLevel >= HighWater));
   assign rdIssue     = !wrIssue && busy_q;
   assign pushDropped = WR_VALID && fifoFull && !wrIssue;

   // Pick this cycle's BRAM operation and work out the next burst/pin state.
   always_comb begin
      state_d     = IDLE;
      bramAddr_d  = bramAddr_q;
      bramDin_d   = bramDin_q;
      bramWe_d    = 1'b0;
      busy_d      = busy_q;
      burstAddr_d = burstAddr_q;
      beatsLeft_d = beatsLeft_q;
      dvalid_d    = (state_q == READ);
      overflow_d  = overflow_q || pushDropped;
      if (wrIssue) begin
         state_d    = WRITE;
         bramAddr_d = fifoEntry[EntryW-1:DATA_W];
         bramDin_d  = fifoEntry[DATA_W-1:0];
         bramWe_d   = 1'b1;
      end else if (rdIssue) begin
         state_d     = READ;
         bramAddr_d  = burstAddr_q;
         burstAddr_d = burstAddr_q + 1'b1;
         beatsLeft_d = beatsLeft_q - 1'b1;
         if (beatsLeft_q == 9'd1) begin
            busy_d = 1'b0;
         end
      end
      if (!busy_q && RD_REQ) begin
         busy_d      = 1'b1;
         burstAddr_d = RD_ADDR;
         beatsLeft_d = (RD_LEN == 8'd0) ? 9'd256 : {1'b0, RD_LEN};
      end
   end

   // Arbiter state, registered BRAM pins and read-return pipeline.
   always_ff @(posedge O_CLK) begin
      if (RESET) begin
         state_q     <= IDLE;
         bramAddr_q  <= '0;
         bramDin_q   <= '0;
         bramWe_q    <= 1'b0;
         busy_q      <= 1'b0;
         burstAddr_q <= '0;
         beatsLeft_q <= '0;
         dvalid_q    <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bramAddr_q  <= bramAddr_d;
         bramDin_q   <= bramDin_d;
         bramWe_q    <= bramWe_d;
         busy_q      <= busy_d;
         burstAddr_q <= burstAddr_d;
         beatsLeft_q <= beatsLeft_d;
         dvalid_q    <= dvalid_d;
         overflow_q  <= overflow_d;
      end
   end

`ifdef FB_ARBITER_STATS_EN
   logic [15:0] dropCount_q;

   // Count dropped capture writes, holding at the maximum instead of wrapping.
   always_ff @(posedge O_CLK) begin
      if (RESET) begin
         dropCount_q <= '0;
      end else if (pushDropped && (dropCount_q != 16'hFFFF)) begin
         dropCount_q <= dropCount_q + 16'd1;
      end
   end

   assign DROP_COUNT = dropCount_q;
`else
   assign DROP_COUNT = 16'h0000;
`endif

   assign BRAM_ADDR = bramAddr_q;
   assign BRAM_DIN  = bramDin_q;
   assign BRAM_WE   = bramWe_q;
   assign RD_BUSY   = busy_q;
   assign RD_DVALID = dvalid_q;
   assign RD_DATA   = BRAM_DOUT;
   assign OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: scoreboard bench for fb_arbiter with a behavioural BRAM.
// Expected writes and read beats are queued as stimulus is driven and
// retired by a monitor on the falling clock edge.
module tb_fb_arbiter;

   localparam int ADDR_W     = 14;
   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 8;

`ifdef FB_ARBITER_STATS_EN
   localparam logic [15:0] ExpDrop = 16'd1;
`else
   localparam logic [15:0] ExpDrop = 16'd0;
`endif

   logic              clock = 1'b0;
   logic              reset;
   logic              wrValid;
   logic [ADDR_W-1:0] wrAddr;
   logic [DATA_W-1:0] wrData;
   logic              rdReq;
   logic [ADDR_W-1:0] rdAddr;
   logic [7:0]        rdLen;
   logic              rdBusy;
   logic              rdDvalid;
   logic [DATA_W-1:0] rdData;
   logic [ADDR_W-1:0] bramAddr;
   logic [DATA_W-1:0] bramDin;
   logic              bramWe;
   logic [DATA_W-1:0] bramDout = '0;
   logic              overflow;
   logic [15:0]       dropCount;

   int compared   = 0;
   int mismatched = 0;
   int maxLevel   = 0;

   logic [ADDR_W+DATA_W-1:0] expWrQ[$];
   logic [DATA_W-1:0]        expRdQ[$];
   logic [ADDR_W+DATA_W-1:0] wrExp;
   logic [DATA_W-1:0]        rdExp;

   logic [DATA_W-1:0] bramMem [1 << ADDR_W];
   bit                written [1 << ADDR_W];

   fb_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .O_CLK      (clock),
      .RESET      (reset),
      .WR_VALID   (wrValid),
      .WR_ADDR    (wrAddr),
      .WR_DATA    (wrData),
      .RD_REQ     (rdReq),
      .RD_ADDR    (rdAddr),
      .RD_LEN     (rdLen),
      .RD_BUSY    (rdBusy),
      .RD_DVALID  (rdDvalid),
      .RD_DATA    (rdData),
      .BRAM_ADDR  (bramAddr),
      .BRAM_DIN   (bramDin),
      .BRAM_WE    (bramWe),
      .BRAM_DOUT  (bramDout),
      .OVERFLOW   (overflow),
      .DROP_COUNT (dropCount)
   );

   // 100 MHz clock.
   always #5 clock = ~clock;

   // Background BRAM contents: every unwritten location reads a known pattern.
   function automatic logic [DATA_W-1:0] preload(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ 8'h5A;
   endfunction

   // Single-port BRAM model, read-first, one cycle read latency.
   always @(posedge clock) begin
      if (bramWe) begin
         bramMem[bramAddr] <= bramDin;
         written[bramAddr] <= 1'b1;
      end
      bramDout <= written[bramAddr] ? bramMem[bramAddr] : preload(bramAddr);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Retire scoreboard entries as the DUT drives BRAM writes and read returns.
   always @(negedge clock) begin
      if (!reset) begin
         if (bramWe) begin
            if (expWrQ.size() == 0) begin
               checkOutput("wrUnexpected", 32'(bramWe), 32'd0);
            end else begin
               wrExp = expWrQ.pop_front();
               checkOutput("wrAddr", 32'(bramAddr), 32'(wrExp[ADDR_W+DATA_W-1:DATA_W]));
               checkOutput("wrData", 32'(bramDin), 32'(wrExp[DATA_W-1:0]));
            end
         end
         if (rdDvalid) begin
            if (expRdQ.size() == 0) begin
               checkOutput("rdUnexpected", 32'(rdDvalid), 32'd0);
            end else begin
               rdExp = expRdQ.pop_front();
               checkOutput("rdData", 32'(rdData), 32'(rdExp));
            end
         end
         if (int'(dut.uFifo.level_q) > maxLevel) begin
            maxLevel = int'(dut.uFifo.level_q);
         end
      end
   end

   // Drive one cycle of inputs, queue what should come out, advance past the edge.
   task automatic applyStimulus(input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                                input logic rr, input logic [ADDR_W-1:0] ra, input logic [7:0] rl,
                                input logic keepWrite);
      int beats;
      wrValid = wv;
      wrAddr  = wa;
      wrData  = wd;
      rdReq   = rr;
      rdAddr  = ra;
      rdLen   = rl;
      if (wv && keepWrite) expWrQ.push_back({wa, wd});
      if (rr) begin
         beats = (rl == 8'd0) ? 256 : int'(rl);
         for (int i = 0; i < beats; i++) expRdQ.push_back(preload(ra + ADDR_W'(i)));
      end
      @(posedge clock);
      #1;
      wrValid = 1'b0;
      rdReq   = 1'b0;
   endtask

   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   task automatic waitDrain(input int budget, input string tag);
      for (int i = 0; i < budget; i++) begin
         if (expWrQ.size() == 0 && expRdQ.size() == 0) break;
         stepCycle();
      end
      checkOutput(tag, 32'(expWrQ.size() + expRdQ.size()), 32'd0);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "We"},       32'(bramWe),    32'd0);
      checkOutput({tag, "Addr"},     32'(bramAddr),  32'd0);
      checkOutput({tag, "Din"},      32'(bramDin),   32'd0);
      checkOutput({tag, "Busy"},     32'(rdBusy),    32'd0);
      checkOutput({tag, "Dvalid"},   32'(rdDvalid),  32'd0);
      checkOutput({tag, "Overflow"}, 32'(overflow),  32'd0);
      checkOutput({tag, "DropCnt"},  32'(dropCount), 32'd0);
   endtask

   // Hard stop if anything hangs.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios feeding the scoreboard.
   initial begin
      reset   = 1'b1;
      wrValid = 1'b0;
      wrAddr  = '0;
      wrData  = '0;
      rdReq   = 1'b0;
      rdAddr  = '0;
      rdLen   = '0;
      repeat (3) stepCycle();
      @(negedge clock);
      checkResetState("rst");
      stepCycle();
      reset = 1'b0;
      stepCycle();

      $display("[TB] single write");
      applyStimulus(1'b1, 14'h0123, 8'hA5, 1'b0, '0, '0, 1'b1);
      @(negedge clock);
      checkOutput("wr1Early", 32'(bramWe), 32'd0);
      stepCycle();
      @(negedge clock);
      checkOutput("wr1Issue", 32'(bramWe), 32'd1);
      checkOutput("wr1Addr", 32'(bramAddr), 32'h0123);
      checkOutput("wr1Data", 32'(bramDin), 32'hA5);
      stepCycle();
      @(negedge clock);
      checkOutput("wr1Once", 32'(bramWe), 32'd0);
      stepCycle();

      $display("[TB] idle burst with address wrap");
      applyStimulus(1'b0, '0, '0, 1'b1, 14'h3FFE, 8'd4, 1'b1);
      @(negedge clock);
      checkOutput("rdBusyAccept", 32'(rdBusy), 32'd1);
      stepCycle();
      waitDrain(40, "burstDrain");
      @(negedge clock);
      checkOutput("rdBusyDone", 32'(rdBusy), 32'd0);
      stepCycle();

      $display("[TB] back-to-back bursts");
      applyStimulus(1'b0, '0, '0, 1'b1, 14'h0600, 8'd1, 1'b1);
      rdReq  = 1'b1;
      rdAddr = 14'h0700;
      rdLen  = 8'd1;
      expRdQ.push_back(preload(14'h0700));
      stepCycle();
      stepCycle();
      rdReq = 1'b0;
      @(negedge clock);
      checkOutput("rdBackToBack", 32'(rdBusy), 32'd1);
      stepCycle();
      waitDrain(40, "b2bDrain");

      $display("[TB] contention");
      applyStimulus(1'b0, '0, '0, 1'b1, 14'h1000, 8'd16, 1'b1);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 14'h2000 + 14'(i), 8'(i * 7 + 3), 1'b0, '0, '0, 1'b1);
      end
      waitDrain(200, "contentionDrain");
      @(negedge clock);
      checkOutput("contentionOverflow", 32'(overflow), 32'd0);
      checkOutput("levelBound", 32'(maxLevel <= FIFO_DEPTH), 32'd1);
      stepCycle();

      $display("[TB] overflow with writes held off");
      applyStimulus(1'b0, '0, '0, 1'b1, 14'h0800, 8'd32, 1'b1);
      force dut.wrIssue = 1'b0;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b1, 14'h2100 + 14'(i), 8'(8'hC0 + i), 1'b0, '0, '0, (i < 8) ? 1'b1 : 1'b0);
      end
      release dut.wrIssue;
      applyStimulus(1'b1, 14'h2109, 8'hC9, 1'b0, '0, '0, 1'b1);
      @(negedge clock);
      checkOutput("overflowSet", 32'(overflow), 32'd1);
      checkOutput("dropCount", 32'(dropCount), 32'(ExpDrop));
      stepCycle();
      waitDrain(300, "overflowDrain");
      @(negedge clock);
      checkOutput("overflowSticky", 32'(overflow), 32'd1);
      checkOutput("dropCountHold", 32'(dropCount), 32'(ExpDrop));
      stepCycle();

      $display("[TB] reset mid-burst");
      applyStimulus(1'b0, '0, '0, 1'b1, 14'h0400, 8'd8, 1'b1);
      for (int i = 0; i < 40; i++) begin
         if (expRdQ.size() <= 5) break;
         stepCycle();
      end
      checkOutput("beat3Reached", 32'(expRdQ.size()), 32'd5);
      reset = 1'b1;
      expRdQ.delete();
      stepCycle();
      @(negedge clock);
      checkResetState("midRst");
      stepCycle();
      reset  = 1'b0;
      rdReq  = 1'b1;
      rdAddr = 14'h0500;
      rdLen  = 8'd2;
      expRdQ.push_back(preload(14'h0500));
      expRdQ.push_back(preload(14'h0501));
      stepCycle();
      rdReq = 1'b0;
      @(negedge clock);
      checkOutput("rdAfterReset", 32'(rdBusy), 32'd1);
      stepCycle();
      waitDrain(40, "postResetDrain");
      repeat (5) stepCycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, BRAM address width.
REQ-002 Parameter DATA_W, default 8, pixel width.
REQ-003 Parameter FIFO_DEPTH, default 8, write-FIFO entries, power of two, >=4.
REQ-004 Port O_CLK  in  1  the single clock; all logic rising-edge.
REQ-005 Port RESET  in  1  reset, synchronous and active-high.
REQ-006 Port WR_VALID  in  1  capture pixel write strobe, may be high every cycle, no back-pressure.
REQ-007 Port WR_ADDR / WR_DATA  in  ADDR_W / DATA_W  capture write address and pixel.
REQ-008 Port RD_REQ  in  1  display prefetch burst request, sampled only when RD_BUSY=0.
REQ-009 Port RD_ADDR / RD_LEN  in  ADDR_W / 8  burst start address and beat count (0 means 256).
REQ-010 Port RD_BUSY  out  1  high from the cycle after acceptance until the last beat is issued.
REQ-011 Port RD_DVALID / RD_DATA  out  1 / DATA_W  read beat returned.
REQ-012 Port BRAM_ADDR / BRAM_DIN / BRAM_WE  out  ADDR_W / DATA_W / 1  single-port BRAM control, registered.
REQ-013 Port BRAM_DOUT  in  DATA_W  BRAM read data, valid one cycle after the address.
REQ-014 Port OVERFLOW  out  1  sticky, a capture write was dropped.
REQ-015 Port DROP_COUNT  out  16  dropped-write count (see Configuration).

Function
REQ-016 States IDLE, WRITE, READ; the state register shall record the BRAM operation issued in the current cycle.
REQ-017 Every WR_VALID cycle shall push {WR_ADDR,WR_DATA} into the write FIFO unless the FIFO is full with no pop in the same cycle.
REQ-018 Full FIFO with a simultaneous pop shall accept the push.
REQ-019 Dropped pushes shall set OVERFLOW until RESET.
REQ-020 Per cycle, the block shall issue exactly one of: a write (FIFO non-empty and (no burst active or FIFO level >= FIFO_DEPTH-2)), else a read beat (burst active), else IDLE with BRAM_WE=0.
REQ-021 A pushed entry shall reach BRAM_WE=1 no earlier than 2 cycles after WR_VALID: push at t, pop/issue at t+1, BRAM pins at t+2.
REQ-022 Writes shall be issued in FIFO order with address and data unmodified.
REQ-023 Burst acceptance (RD_REQ=1 and RD_BUSY=0) shall latch RD_ADDR and RD_LEN; beats shall use consecutive addresses, wrapping modulo 2^ADDR_W.
REQ-024 RD_DVALID shall rise 2 cycles after the beat's issue cycle, with RD_DATA=BRAM_DOUT; beats shall return in order with exactly RD_LEN pulses per burst.
REQ-025 A beat issue shall drive BRAM_WE=0; BRAM_DIN shall be don't-care.
REQ-026 RD_BUSY shall fall the cycle after the last beat issues, and a new RD_REQ shall be accepted that cycle.

Reset
REQ-027 RESET shall empty the FIFO, abort any burst, and enter IDLE.
REQ-028 RESET shall force BRAM_WE=0, BRAM_ADDR=0, BRAM_DIN=0, RD_BUSY=0, RD_DVALID=0, OVERFLOW=0 and DROP_COUNT=0 on the next edge.
REQ-029 Beats in flight at reset shall not produce RD_DVALID.

Configuration
REQ-030 Macro FB_ARBITER_STATS_EN: when defined, DROP_COUNT shall increment by 1 per dropped push and saturate at 16'hFFFF.
REQ-031 When FB_ARBITER_STATS_EN is undefined, DROP_COUNT shall be constant 0 and no counter shall be synthesised; the port shall remain present.

Structure
REQ-032 A shared package fb_arb_pkg shall hold the state enumeration, the default ADDR_W/DATA_W constants and the high-water offset of 2.
REQ-033 The write FIFO shall be the sub-module fb_wr_fifo (synchronous, registered level count, full/empty flags).

Verification
REQ-034 Single write: WR_VALID for 1 cycle, addr 0x0123, data 0xA5, no reads -> BRAM_WE=1 with BRAM_ADDR=0x0123 and BRAM_DIN=0xA5 exactly 2 cycles later, once.
REQ-035 Idle burst: RD_REQ with addr 0x3FFE, len 4 -> BRAM_ADDR 0x3FFE, 0x3FFF, 0x0000, 0x0001, then 4 RD_DVALID pulses returning the preloaded data in order, and RD_BUSY low afterwards.
REQ-036 Contention: 20 consecutive writes during a len-16 burst -> all 20 writes land, all 16 beats return, OVERFLOW=0, and FIFO level never exceeds FIFO_DEPTH.
REQ-037 Overflow: FIFO full with a burst pinned active by the high-water rule fed one extra push blocked -> OVERFLOW=1, and DROP_COUNT=1 with the macro or 0 without.
REQ-038 Reset mid-burst: RESET asserted at beat 3 of 8 -> no further RD_DVALID, BRAM_WE=0, and a new RD_REQ is accepted on the first cycle after RESET deasserts.
